// File: rtl/arc4_keystream.sv
// ARC4 (RC4) keystream generator: 256-cycle state init, 512-cycle key schedule,
// then one keystream byte per four cycles over a valid/ready handshake.
module arc4_keystream #(
    parameter int KEY_BYTES = 16,
    parameter int DROP      = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [4:0]             key_len,
    input  logic                   abort,
    output logic                   busy,
    output logic                   err,
    output logic                   ks_valid,
    input  logic                   ks_ready,
    output logic [7:0]             ks_data
);

    localparam int DW = $clog2(DROP + 2);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        KSA_J,
        KSA_SWAP,
        PRGA_I,
        PRGA_J,
        PRGA_SWAP,
        OUT
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_s [256];
    logic [7:0]             r_i;
    logic [7:0]             r_j;
    logic [7:0]             r_k;
    logic [DW-1:0]          r_drop;
    logic [8*KEY_BYTES-1:0] r_key;
    logic [4:0]             r_keyLen;
    logic [4:0]             r_keyIdx;
    logic                   r_busy;
    logic                   r_err;
    logic                   r_ksValid;

    logic [7:0]             w_si;
    logic [7:0]             w_sj;
    logic [7:0]             w_t;
    logic [7:0]             w_kNext;
    logic [7:0]             w_keyByte;
    logic [4:0]             w_keyIdxNext;
    logic                   w_lenOk;
    logic                   w_dropDone;

    assign w_si = r_s[r_i];
    assign w_sj = r_s[r_j];
    assign w_t  = w_si + w_sj;

    // The output lookup sees the post-swap array, so the two swapped slots are forwarded.
    assign w_kNext = (w_t == r_i) ? w_sj :
                     (w_t == r_j) ? w_si :
                     r_s[w_t];

    assign w_lenOk      = (key_len != 5'd0) && ({27'd0, key_len} <= KEY_BYTES);
    assign w_dropDone   = (r_drop == DW'(DROP));
    assign w_keyIdxNext = (r_keyIdx == r_keyLen - 5'd1) ? 5'd0 : r_keyIdx + 5'd1;

    // r_keyIdx tracks i mod key_len incrementally, avoiding a divider.
    always_comb begin
        w_keyByte = 8'd0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (r_keyIdx == 5'(b)) begin
                w_keyByte = r_key[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

    // S has no reset: INIT rewrites every entry before it is read.
    always_ff @(posedge clk) begin
        if (r_state == INIT) begin
            r_s[r_i] <= r_i;
        end else if (r_state == KSA_SWAP || r_state == PRGA_SWAP) begin
            r_s[r_i] <= w_sj;
            r_s[r_j] <= w_si;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_i       <= 8'd0;
            r_j       <= 8'd0;
            r_k       <= 8'd0;
            r_drop    <= '0;
            r_key     <= '0;
            r_keyLen  <= 5'd0;
            r_keyIdx  <= 5'd0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_ksValid <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (abort) begin
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_ksValid <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            if (w_lenOk) begin
                                r_key    <= key;
                                r_keyLen <= key_len;
                                r_keyIdx <= 5'd0;
                                r_i      <= 8'd0;
                                r_j      <= 8'd0;
                                r_drop   <= '0;
                                r_busy   <= 1'b1;
                                r_state  <= INIT;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    INIT: begin
                        r_i <= r_i + 8'd1;
                        if (r_i == 8'hFF) begin
                            r_state <= KSA_J;
                        end
                    end
                    KSA_J: begin
                        r_j     <= r_j + w_si + w_keyByte;
                        r_state <= KSA_SWAP;
                    end
                    KSA_SWAP: begin
                        r_i      <= r_i + 8'd1;
                        r_keyIdx <= w_keyIdxNext;
                        if (r_i == 8'hFF) begin
                            r_j     <= 8'd0;
                            r_state <= PRGA_I;
                        end else begin
                            r_state <= KSA_J;
                        end
                    end
                    PRGA_I: begin
                        r_i     <= r_i + 8'd1;
                        r_state <= PRGA_J;
                    end
                    PRGA_J: begin
                        r_j     <= r_j + w_si;
                        r_state <= PRGA_SWAP;
                    end
                    PRGA_SWAP: begin
                        r_k <= w_kNext;
                        if (!w_dropDone) begin
                            r_drop  <= r_drop + 1'b1;
                            r_state <= PRGA_I;
                        end else begin
                            r_ksValid <= 1'b1;
                            r_state   <= OUT;
                        end
                    end
                    OUT: begin
                        if (ks_ready) begin
                            r_ksValid <= 1'b0;
                            r_state   <= PRGA_I;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign busy     = r_busy;
    assign err      = r_err;
    assign ks_valid = r_ksValid;
    assign ks_data  = r_k;

endmodule

// File: tb/tb_arc4_keystream.sv
// Directed testbench for arc4_keystream: known RC4 vectors, drop, errors,
// backpressure, abort and asynchronous reset.
module tb_arc4_keystream;

    localparam logic [79:0]  EXP_KEY  = 80'hEB9F7781B734CA72A719;
    localparam logic [39:0]  EXP_WIKI = 40'h6044DB6D41;
    localparam logic [127:0] KEY_KEY  = {24'h4B6579, 104'hC3C3_C3C3_C3C3_C3C3_C3C3_C3C3_C3};
    localparam logic [127:0] KEY_WIKI = {32'h57696B69, 96'h1122_3344_5566_7788_99AA_BBCC};

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic [4:0]   key_len;
    logic         abort;
    logic         ks_ready;
    logic         busy0, err0, ksValid0;
    logic [7:0]   ksData0;
    logic         busy2, err2, ksValid2;
    logic [7:0]   ksData2;

    int           nCompared = 0;
    int           nMismatched = 0;
    logic [7:0]   gotData [16];
    int           validCyc [16];
    int           gotCount;
    int           timedOut;
    int           holdDrops;
    int           holdChanges;
    int           dropLat;
    logic [7:0]   dropData;

    arc4_keystream #(.KEY_BYTES(16), .DROP(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .key_len(key_len),
        .abort(abort), .busy(busy0), .err(err0), .ks_valid(ksValid0),
        .ks_ready(ks_ready), .ks_data(ksData0)
    );

    arc4_keystream #(.KEY_BYTES(16), .DROP(2)) dutDrop (
        .clk(clk), .rst_n(rst_n), .start(start), .key(key), .key_len(key_len),
        .abort(abort), .busy(busy2), .err(err2), .ks_valid(ksValid2),
        .ks_ready(ks_ready), .ks_data(ksData2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // All helpers are entered and left 1 time unit after a rising edge.
    task automatic go_idle();
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
    endtask

    task automatic issue_start(input logic [127:0] k, input logic [4:0] len);
        key     = k;
        key_len = len;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic collect(input int nBytes, input int holdAt, input int holdCycles);
        int cyc = 0;
        gotCount = 0; timedOut = 0; holdDrops = 0; holdChanges = 0;
        dropLat = -1; dropData = 8'd0;
        while (gotCount < nBytes && timedOut == 0) begin
            @(posedge clk); #1; cyc++;
            if (ksValid2 && dropLat < 0) begin
                dropLat  = cyc;
                dropData = ksData2;
            end
            if (ksValid0) begin
                gotData[gotCount]  = ksData0;
                validCyc[gotCount] = cyc;
                if (gotCount == holdAt) begin
                    ks_ready = 1'b0;
                    repeat (holdCycles) begin
                        @(posedge clk); #1; cyc++;
                        if (ksValid0 !== 1'b1) holdDrops++;
                        if (ksData0 !== gotData[gotCount]) holdChanges++;
                    end
                    ks_ready = 1'b1;
                end
                gotCount++;
            end
            if (cyc > 3000) timedOut = 1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        nCompared++; if (busy0 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy0); end
        nCompared++; if (err0 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_err: got %b expected 0", err0); end
        nCompared++; if (ksValid0 !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", ksValid0); end
        nCompared++; if (ksData0 !== 8'd0) begin nMismatched++; $display("[TB] FAIL reset_data: got %02h expected 00", ksData0); end
        rst_n = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        nCompared++; if (busy0 !== 1'b0 || ksValid0 !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_after_reset: busy %b valid %b expected 0 0", busy0, ksValid0); end
    endtask

    task automatic test_key_vector();
        go_idle();
        issue_start(KEY_KEY, 5'd3);
        collect(10, -1, 0);
        nCompared++; if (timedOut !== 0) begin nMismatched++; $display("[TB] FAIL key_timeout: got %0d bytes expected 10", gotCount); end
        nCompared++; if (validCyc[0] !== 771) begin nMismatched++; $display("[TB] FAIL key_latency: got %0d expected 771", validCyc[0]); end
        for (int b = 0; b < 10; b++) begin
            nCompared++;
            if (gotData[b] !== EXP_KEY[8*(9-b) +: 8]) begin
                nMismatched++; $display("[TB] FAIL key_byte%0d: got %02h expected %02h", b, gotData[b], EXP_KEY[8*(9-b) +: 8]);
            end
        end
        for (int b = 1; b < 10; b++) begin
            nCompared++;
            if (validCyc[b] - validCyc[b-1] !== 4) begin
                nMismatched++; $display("[TB] FAIL key_gap%0d: got %0d expected 4", b, validCyc[b] - validCyc[b-1]);
            end
        end
    endtask

    task automatic test_wiki_drop();
        go_idle();
        issue_start(KEY_WIKI, 5'd4);
        collect(5, -1, 0);
        nCompared++; if (timedOut !== 0) begin nMismatched++; $display("[TB] FAIL wiki_timeout: got %0d bytes expected 5", gotCount); end
        nCompared++; if (validCyc[0] !== 771) begin nMismatched++; $display("[TB] FAIL wiki_latency: got %0d expected 771", validCyc[0]); end
        for (int b = 0; b < 5; b++) begin
            nCompared++;
            if (gotData[b] !== EXP_WIKI[8*(4-b) +: 8]) begin
                nMismatched++; $display("[TB] FAIL wiki_byte%0d: got %02h expected %02h", b, gotData[b], EXP_WIKI[8*(4-b) +: 8]);
            end
        end
        nCompared++; if (dropLat !== 777) begin nMismatched++; $display("[TB] FAIL drop2_latency: got %0d expected 777", dropLat); end
        nCompared++; if (dropData !== 8'hDB) begin nMismatched++; $display("[TB] FAIL drop2_byte: got %02h expected db", dropData); end
    endtask

    task automatic test_err();
        go_idle();
        key = KEY_KEY; key_len = 5'd0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        nCompared++; if (err0 !== 1'b1 || busy0 !== 1'b0) begin nMismatched++; $display("[TB] FAIL err_len0: err %b busy %b expected 1 0", err0, busy0); end
        @(posedge clk); #1;
        nCompared++; if (err0 !== 1'b0) begin nMismatched++; $display("[TB] FAIL err_len0_pulse: got %b expected 0", err0); end
        key_len = 5'd17; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        nCompared++; if (err0 !== 1'b1 || busy0 !== 1'b0) begin nMismatched++; $display("[TB] FAIL err_len17: err %b busy %b expected 1 0", err0, busy0); end
        @(posedge clk); #1;
        nCompared++; if (err0 !== 1'b0 || busy0 !== 1'b0) begin nMismatched++; $display("[TB] FAIL err_len17_pulse: err %b busy %b expected 0 0", err0, busy0); end
        issue_start(KEY_KEY, 5'd3);
        // An illegal start while busy must be ignored, not flagged.
        key_len = 5'd0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        nCompared++; if (err0 !== 1'b0 || busy0 !== 1'b1) begin nMismatched++; $display("[TB] FAIL start_ignored_busy: err %b busy %b expected 0 1", err0, busy0); end
        collect(3, -1, 0);
        nCompared++; if (validCyc[0] !== 770) begin nMismatched++; $display("[TB] FAIL err_restart_latency: got %0d expected 770", validCyc[0]); end
        for (int b = 0; b < 3; b++) begin
            nCompared++;
            if (gotData[b] !== EXP_KEY[8*(9-b) +: 8]) begin
                nMismatched++; $display("[TB] FAIL err_restart_byte%0d: got %02h expected %02h", b, gotData[b], EXP_KEY[8*(9-b) +: 8]);
            end
        end
    endtask

    task automatic test_backpressure();
        go_idle();
        issue_start(KEY_KEY, 5'd3);
        collect(10, 2, 20);
        nCompared++; if (timedOut !== 0) begin nMismatched++; $display("[TB] FAIL bp_timeout: got %0d bytes expected 10", gotCount); end
        nCompared++; if (holdDrops !== 0) begin nMismatched++; $display("[TB] FAIL bp_valid_held: got %0d drops expected 0", holdDrops); end
        nCompared++; if (holdChanges !== 0) begin nMismatched++; $display("[TB] FAIL bp_data_held: got %0d changes expected 0", holdChanges); end
        nCompared++; if (validCyc[3] - validCyc[2] !== 24) begin nMismatched++; $display("[TB] FAIL bp_gap: got %0d expected 24", validCyc[3] - validCyc[2]); end
        for (int b = 0; b < 10; b++) begin
            nCompared++;
            if (gotData[b] !== EXP_KEY[8*(9-b) +: 8]) begin
                nMismatched++; $display("[TB] FAIL bp_byte%0d: got %02h expected %02h", b, gotData[b], EXP_KEY[8*(9-b) +: 8]);
            end
        end
    endtask

    task automatic test_abort();
        go_idle();
        key = KEY_KEY; key_len = 5'd3; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1; start = 1'b0; abort = 1'b0;
        nCompared++; if (busy0 !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_over_start: busy %b expected 0", busy0); end
        issue_start(KEY_KEY, 5'd3);
        repeat (300) begin @(posedge clk); #1; end
        nCompared++; if (busy0 !== 1'b1) begin nMismatched++; $display("[TB] FAIL abort_pre_busy: got %b expected 1", busy0); end
        abort = 1'b1;
        @(posedge clk); #1; abort = 1'b0;
        nCompared++; if (busy0 !== 1'b0 || ksValid0 !== 1'b0) begin nMismatched++; $display("[TB] FAIL abort_idle: busy %b valid %b expected 0 0", busy0, ksValid0); end
        issue_start(KEY_KEY, 5'd3);
        nCompared++; if (busy0 !== 1'b1) begin nMismatched++; $display("[TB] FAIL abort_restart_busy: got %b expected 1", busy0); end
        collect(10, -1, 0);
        nCompared++; if (validCyc[0] !== 771) begin nMismatched++; $display("[TB] FAIL abort_latency: got %0d expected 771", validCyc[0]); end
        for (int b = 0; b < 10; b++) begin
            nCompared++;
            if (gotData[b] !== EXP_KEY[8*(9-b) +: 8]) begin
                nMismatched++; $display("[TB] FAIL abort_byte%0d: got %02h expected %02h", b, gotData[b], EXP_KEY[8*(9-b) +: 8]);
            end
        end
    endtask

    task automatic test_async_reset();
        int activity = 0;
        go_idle();
        issue_start(KEY_KEY, 5'd3);
        collect(3, -1, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        nCompared++; if (busy0 !== 1'b0 || err0 !== 1'b0) begin nMismatched++; $display("[TB] FAIL async_rst_ctrl: busy %b err %b expected 0 0", busy0, err0); end
        nCompared++; if (ksValid0 !== 1'b0 || ksData0 !== 8'd0) begin nMismatched++; $display("[TB] FAIL async_rst_out: valid %b data %02h expected 0 00", ksValid0, ksData0); end
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if (ksValid0 !== 1'b0 || busy0 !== 1'b0) activity++;
        end
        nCompared++; if (activity !== 0) begin nMismatched++; $display("[TB] FAIL post_reset_quiet: got %0d active cycles expected 0", activity); end
        issue_start(KEY_KEY, 5'd3);
        collect(10, -1, 0);
        nCompared++; if (validCyc[0] !== 771) begin nMismatched++; $display("[TB] FAIL rst_restart_latency: got %0d expected 771", validCyc[0]); end
        for (int b = 0; b < 10; b++) begin
            nCompared++;
            if (gotData[b] !== EXP_KEY[8*(9-b) +: 8]) begin
                nMismatched++; $display("[TB] FAIL rst_restart_byte%0d: got %02h expected %02h", b, gotData[b], EXP_KEY[8*(9-b) +: 8]);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        ks_ready = 1'b1;
        key      = '0;
        key_len  = 5'd0;
        test_reset();
        test_key_vector();
        test_wiki_drop();
        test_err();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
